program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//   Writer side of the program-memory interface: assembles 16-bit BIP instructions
//   from a byte stream (UART receiver), writes them to program memory from
//   address 0 upward, then raises start_bip so the program counter runs.
//   Sits between the UART receiver and program memory / CPU start logic.
// PARAMETERS
//   AB  11  program-memory address width (depth 2**AB words)
//   DB  16  instruction width; fixed at 16 (two bytes, high byte first)
// PORTS
//   clk          in   1   system clock, all logic on posedge
//   reset_n      in   1   asynchronous, active-low reset
//   rx_data      in   8   received byte
//   rx_done      in   1   one-cycle strobe: rx_data valid
//   bip_halted   in   1   CPU reached HLT (level)
//   prog_addr    out  AB  program-memory write address
//   prog_data    out  DB  program-memory write data
//   prog_we      out  1   one-cycle write strobe
//   start_bip    out  1   level: CPU run enable
//   load_done    out  1   level: load+run finished
//   load_error   out  1   level: load aborted (checksum only, else tied 0)
// BEHAVIOUR
//   Reset: all outputs 0, byte count cleared, state LOAD_HI, write pointer 0.
//   States: LOAD_HI, LOAD_LO, (CHECK), RUN, DONE.
//   LOAD_HI: rx_done -> hi byte <= rx_data, go LOAD_LO.
//   LOAD_LO: rx_done -> next cycle prog_we=1, prog_data={hi,rx_data},
//     prog_addr=write pointer; pointer increments after the write.
//     Instruction 16'h0000 (HLT) ends load: go RUN (or CHECK).
//     Otherwise, a write to address 2**AB-1 also ends load (memory full).
//     Else return to LOAD_HI; a byte in the prog_we cycle is accepted normally.
//   RUN: start_bip=1 from cycle after the final prog_we; rx_done ignored.
//     bip_halted=1 -> start_bip=0, load_done=1, go DONE (1-cycle latency).
//   DONE: load_done held; rx_done -> load_done=0, pointer=0, byte = hi byte
//     of new instruction 0, go LOAD_LO.
//   Pointer never wraps during a load; prog_we never asserted outside load.
//   rx_done and bip_halted together in RUN: bip_halted wins, byte dropped.
//   reset_n low mid-load: partial instruction discarded, reload from addr 0.
// CONFIGURATION
//   PROGRAM_LOADER_CHECKSUM_EN defined: after the terminating write go CHECK;
//     next byte compared to XOR of all loaded bytes. Match -> RUN.
//     Mismatch -> load_error=1, start_bip stays 0, go DONE (load_done=0);
//     next rx_done clears load_error and restarts as in DONE.
//   Undefined: no CHECK state, load_error constant 0.
// TESTING
//   1 Reset asserted mid-run -> all outputs 0 immediately, next bytes load at addr 0.
//   2 Bytes 08,05,00,00 -> prog_we addr0 data 0805, addr1 data 0000, then
//     start_bip=1 next cycle, load_done=0.
//   3 In RUN pulse bip_halted -> start_bip=0, load_done=1 one cycle later;
//     then byte 10 -> load_done=0, next byte 01 writes 1001 at addr 0.
//   4 Byte 08, reset_n pulse, bytes 18,03 -> single write addr0 data 1803.
//   5 AB=2, four instrs 0801 -> writes addr0..3, start_bip=1 after addr3 write.
//   6 CHECKSUM_EN: 08,05,00,00,0D -> RUN; same with checksum 0E ->
//     load_error=1, start_bip=0.

Source files
------------

// File: rtl/program_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : program_loader                                                |
// | Purpose  : Assembles 16-bit BIP instructions from a received byte stream |
// |            (high byte first), writes them to program memory from address |
// |            0 upward, then enables the CPU until it halts.                |
// | Options  : PROGRAM_LOADER_CHECKSUM_EN - after the terminating write, one |
// |            extra byte must equal the XOR of all loaded bytes before the  |
// |            CPU is started; a mismatch raises load_error instead.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module program_loader #(
  parameter int AB = 11,
  parameter int DB = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          bip_halted,
  output logic [AB-1:0] prog_addr,
  output logic [DB-1:0] prog_data,
  output logic          prog_we,
  output logic          start_bip,
  output logic          load_done,
  output logic          load_error
);

  typedef enum logic [2:0] {
    LOAD_HI = 3'd0,
    LOAD_LO = 3'd1,
    CHECK   = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [AB-1:0] PTR_MAX = '1;

  state_t        state_q, state_d;
  logic [7:0]    hi_q, hi_d;
  logic [AB-1:0] ptr_q, ptr_d;
  logic [AB-1:0] addr_q, addr_d;
  logic [DB-1:0] data_q, data_d;
  logic          we_q, we_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic [15:0]   instr_w;

  assign instr_w = {hi_q, rx_data};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       err_q, err_d;
  // Load-checksum accumulator and abort flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end
  assign load_error = err_q;
`else
  assign load_error = 1'b0;
`endif

  // State, pointer and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD_HI;
      hi_q    <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output decode; prog_we is a single-cycle strobe
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    start_d = start_q;
    done_d  = done_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    case (state_q)
      LOAD_HI: begin
        if (rx_done) begin
          hi_d    = rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
          state_d = LOAD_LO;
        end
      end
      LOAD_LO: begin
        if (rx_done) begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          data_d = DB'(instr_w);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          // Saturate at the top address so the pointer never wraps
          if (ptr_q != PTR_MAX) ptr_d = ptr_q + 1'b1;
          if (instr_w == 16'h0000 || ptr_q == PTR_MAX) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = RUN;
`endif
          end else begin
            state_d = LOAD_HI;
          end
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (rx_done) begin
          if (rx_data == csum_q) begin
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
`endif
      RUN: begin
        // Halt has priority over any byte arriving in the same cycle
        if (bip_halted) begin
          start_d = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          start_d = 1'b1;
        end
      end
      DONE: begin
        // A new byte is the high byte of instruction 0 of the next program
        if (rx_done) begin
          done_d  = 1'b0;
          ptr_d   = '0;
          hi_d    = rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          err_d   = 1'b0;
          csum_d  = rx_data;
`endif
          state_d = LOAD_LO;
        end
      end
      default: state_d = LOAD_HI;
    endcase
  end

  assign prog_addr = addr_q;
  assign prog_data = data_q;
  assign prog_we   = we_q;
  assign start_bip = start_q;
  assign load_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_program_loader                                             |
// | Purpose  : Self-checking bench for program_loader; expected memory       |
// |            writes are queued by the stimulus and popped by a monitor.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data_a = '0, rx_data_b = '0;
  logic        rx_done_a = 1'b0, rx_done_b = 1'b0;
  logic        halted_a = 1'b0, halted_b = 1'b0;

  logic [10:0] addr_a;
  logic [15:0] data_a;
  logic        we_a, start_a, done_a, err_a;
  logic [1:0]  addr_b;
  logic [15:0] data_b;
  logic        we_b, start_b, done_b, err_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [10:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_a[$];
  wr_t exp_b[$];

  program_loader #(.AB(11), .DB(16)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data_a), .rx_done(rx_done_a),
    .bip_halted(halted_a), .prog_addr(addr_a), .prog_data(data_a),
    .prog_we(we_a), .start_bip(start_a), .load_done(done_a), .load_error(err_a)
  );

  program_loader #(.AB(2), .DB(16)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data_b), .rx_done(rx_done_b),
    .bip_halted(halted_b), .prog_addr(addr_b), .prog_data(data_b),
    .prog_we(we_b), .start_bip(start_b), .load_done(done_b), .load_error(err_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL wr_a unexpected: addr %0h data %0h, none expected", addr_a, data_a);
      end else begin
        wr_t e;
        e = exp_a.pop_front();
        if (addr_a !== e.addr || data_a !== e.data) begin
          errors++;
          $display("FAIL wr_a: addr %0h data %0h expected addr %0h data %0h",
                   addr_a, data_a, e.addr, e.data);
        end
      end
    end
    if (we_b === 1'b1) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL wr_b unexpected: addr %0h data %0h, none expected", addr_b, data_b);
      end else begin
        wr_t e;
        e = exp_b.pop_front();
        if ({9'd0, addr_b} !== e.addr || data_b !== e.data) begin
          errors++;
          $display("FAIL wr_b: addr %0h data %0h expected addr %0h data %0h",
                   addr_b, data_b, e.addr, e.data);
        end
      end
    end
  end

  task automatic exp_wr(input bit sel, input logic [10:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    if (sel) exp_b.push_back(e);
    else     exp_a.push_back(e);
  endtask

  // One-cycle rx_done strobe; returns #1 after the edge that consumed the byte
  task automatic send(input bit sel, input logic [7:0] b);
    @(posedge clk);
    #1;
    if (sel) begin rx_data_b = b; rx_done_b = 1'b1; end
    else     begin rx_data_a = b; rx_done_a = 1'b1; end
    @(posedge clk);
    #1;
    rx_done_a = 1'b0;
    rx_done_b = 1'b0;
  endtask

  // Sends the checksum byte only when the option is built in
  task automatic end_load(input bit sel, input logic [7:0] ck);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(sel, ck);
`else
    if (ck === 8'hxx) $display("unused");
`endif
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic halt_a;
    @(posedge clk);
    #1 halted_a = 1'b1;
    @(posedge clk);
    #1 halted_a = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_we", {31'd0, we_a}, 32'd0);
    check("reset_start", {31'd0, start_a}, 32'd0);
    check("reset_done", {31'd0, done_a}, 32'd0);
    check("reset_err", {31'd0, err_a}, 32'd0);
    reset_n = 1'b1;

    // Two instructions, HLT terminates the load
    exp_wr(0, 11'd0, 16'h0805);
    exp_wr(0, 11'd1, 16'h0000);
    send(0, 8'h08); send(0, 8'h05); send(0, 8'h00); send(0, 8'h00);
    end_load(0, 8'h0D);
    check("t2_start_first", {31'd0, start_a}, 32'd0);
    step;
    check("t2_start", {31'd0, start_a}, 32'd1);
    check("t2_done", {31'd0, done_a}, 32'd0);

    // Bytes during RUN are ignored
    send(0, 8'h77);
    check("run_ignore_start", {31'd0, start_a}, 32'd1);

    // Halt, then restart a new program from address 0
    halt_a;
    check("t3_start", {31'd0, start_a}, 32'd0);
    check("t3_done", {31'd0, done_a}, 32'd1);
    step;
    check("t3_done_held", {31'd0, done_a}, 32'd1);
    send(0, 8'h10);
    check("t3_done_clr", {31'd0, done_a}, 32'd0);
    exp_wr(0, 11'd0, 16'h1001);
    exp_wr(0, 11'd1, 16'h0000);
    send(0, 8'h01); send(0, 8'h00); send(0, 8'h00);
    end_load(0, 8'h11);
    step;
    check("t3_start_run", {31'd0, start_a}, 32'd1);

    // Asynchronous reset mid-run clears outputs without a clock edge
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t1_start", {31'd0, start_a}, 32'd0);
    check("t1_we", {31'd0, we_a}, 32'd0);
    check("t1_addr", {21'd0, addr_a}, 32'd0);
    check("t1_data", {16'd0, data_a}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_wr(0, 11'd0, 16'h2233);
    send(0, 8'h22); send(0, 8'h33);

    // Partial instruction discarded by reset
    send(0, 8'h08);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_wr(0, 11'd0, 16'h1803);
    exp_wr(0, 11'd1, 16'h0000);
    send(0, 8'h18); send(0, 8'h03); send(0, 8'h00); send(0, 8'h00);
    end_load(0, 8'h1B);
    step;
    check("t4_start", {31'd0, start_a}, 32'd1);

    // Memory full on a 4-word memory ends the load without HLT
    for (int i = 0; i < 4; i++) begin
      exp_wr(1, 11'(i), 16'h0801);
      send(1, 8'h08); send(1, 8'h01);
    end
    end_load(1, 8'h00);
    check("t5_start_first", {31'd0, start_b}, 32'd0);
    step;
    check("t5_start", {31'd0, start_b}, 32'd1);
    send(1, 8'h55); send(1, 8'h66);
    check("t5_run_hold", {31'd0, start_b}, 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Wrong checksum aborts the load
    halt_a;
    exp_wr(0, 11'd0, 16'h0805);
    exp_wr(0, 11'd1, 16'h0000);
    send(0, 8'h08); send(0, 8'h05); send(0, 8'h00); send(0, 8'h00);
    send(0, 8'h0E);
    check("t6_err", {31'd0, err_a}, 32'd1);
    check("t6_done", {31'd0, done_a}, 32'd0);
    step;
    check("t6_start", {31'd0, start_a}, 32'd0);
    exp_wr(0, 11'd0, 16'h0805);
    exp_wr(0, 11'd1, 16'h0000);
    send(0, 8'h08);
    check("t6_err_clr", {31'd0, err_a}, 32'd0);
    send(0, 8'h05); send(0, 8'h00); send(0, 8'h00);
    send(0, 8'h0D);
    step;
    check("t6_start_ok", {31'd0, start_a}, 32'd1);
`endif

    // Halt and a byte in the same RUN cycle: halt wins, byte dropped
    @(posedge clk);
    #1;
    halted_a = 1'b1; rx_data_a = 8'h44; rx_done_a = 1'b1;
    @(posedge clk);
    #1;
    halted_a = 1'b0; rx_done_a = 1'b0;
    check("coll_done", {31'd0, done_a}, 32'd1);
    check("coll_start", {31'd0, start_a}, 32'd0);
    repeat (3) step;
    check("coll_done_held", {31'd0, done_a}, 32'd1);

    repeat (4) step;
    check("pending_a", exp_a.size(), 32'd0);
    check("pending_b", exp_b.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
